// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants, FSM state type and helpers for the uart_rx_fifo receiver.
package uart_rx_fifo_pkg;

    localparam int unsigned OsRate   = 16;
    localparam int unsigned DataBits = 8;

    localparam logic [3:0] SampleLo  = 4'd7;
    localparam logic [3:0] SampleMid = 4'd8;
    localparam logic [3:0] SampleHi  = 4'd9;
    localparam logic [3:0] BitEnd    = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBrk
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream plus status pulses from the receiver to a fabric consumer.
interface uart_rx_fifo_if #(
    parameter int unsigned CW = 5
);
    import uart_rx_fifo_pkg::*;

    logic [DataBits-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                frame_err;
    logic                overrun;
    logic [CW-1:0]       fifo_count;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output fifo_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  fifo_count,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO succeeds only
// when a read happens in the same cycle.
module uart_rx_fifo_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16,
    localparam int unsigned AW   = $clog2(Depth),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote, feeding a
// first-word-fall-through byte FIFO.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             rx,
    uart_rx_fifo_if.master   bus
);

    localparam int unsigned DIV = (CLK_HZ + (OsRate * BAUD) / 2) / (OsRate * BAUD);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TickMax = TW'(DIV - 1);

    logic                rx_meta;
    logic                rxs;
    logic [TW-1:0]       tcnt_q;
    logic                os_tick;
    rx_state_e           state_q;
    logic [3:0]          scnt_q;
    logic [2:0]          bit_idx_q;
    logic [DataBits-1:0] shift_q;
    logic [2:0]          samp_q;
    logic                frame_err_q;
    logic                maj_now;
    logic                maj_reg;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Restarting the divider on the start edge keeps sample points centred in each bit.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tcnt_q <= '0;
        end else if ((state_q == StIdle && !rxs) || os_tick) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    assign os_tick = (tcnt_q == TickMax);
    assign maj_now = majority3(samp_q[0], samp_q[1], rxs);
    assign maj_reg = majority3(samp_q[0], samp_q[1], samp_q[2]);

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= StIdle;
            scnt_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            samp_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (os_tick && state_q != StIdle && state_q != StBrk) begin
                scnt_q <= scnt_q + 4'd1;
                if (scnt_q == SampleLo)  samp_q[0] <= rxs;
                if (scnt_q == SampleMid) samp_q[1] <= rxs;
                if (scnt_q == SampleHi)  samp_q[2] <= rxs;
            end
            case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_q <= StStart;
                        scnt_q  <= '0;
                    end
                end
                StStart: begin
                    if (os_tick && scnt_q == SampleHi && maj_now) begin
                        state_q <= StIdle;
                    end else if (os_tick && scnt_q == BitEnd) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                    end
                end
                StData: begin
                    if (os_tick && scnt_q == BitEnd) begin
                        shift_q <= {maj_reg, shift_q[DataBits-1:1]};
                        if (bit_idx_q == 3'(DataBits - 1)) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    // Exit mid stop bit so an early next start edge is not missed.
                    if (os_tick && scnt_q == SampleHi) begin
                        if (maj_now) begin
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBrk;
                        end
                    end
                end
                StBrk: begin
                    if (rxs) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign push = (state_q == StStop) && os_tick && (scnt_q == SampleHi) && maj_now;
    assign pop  = ~empty & bus.rx_ready;

    uart_rx_fifo_sync_fifo #(
        .Width (DataBits),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rstn),
        .wr_en   (push),
        .wr_data (shift_q),
        .rd_en   (pop),
        .rd_data (bus.rx_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bus.rx_valid   = ~empty;
    assign bus.fifo_count = count;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = push & full & ~pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit: a frame table plus
// hand-written latency, framing, glitch, overrun and reset sequences.
module tb_uart_rx_fifo;

    logic sys_clk  = 1'b0;
    logic sys_rstn = 1'b0;
    logic rx       = 1'b1;

    uart_rx_fifo_if #(.CW(5)) bus ();

    uart_rx_fifo #(
        .CLK_HZ     (1_843_200),
        .BAUD       (115200),
        .FIFO_DEPTH (16)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor on the falling edge; cyc then names the cycle that started at the last rise.
    logic [7:0]  popped [$];
    int unsigned ferr_cnt = 0;
    int unsigned ovr_cnt  = 0;
    int unsigned ovr_cyc  = 0;
    int unsigned rise_cyc = 0;
    logic        prev_valid = 1'b0;

    always @(negedge sys_clk) begin
        if (bus.rx_valid && bus.rx_ready) popped.push_back(bus.rx_data);
        if (bus.frame_err) ferr_cnt++;
        if (bus.overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rx_valid;
    end

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          rd_idx = 0;
    int unsigned frame_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        frame_k = cyc;
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(16);
        end
        rx = stop;
        step(16);
    endtask

    task automatic check_next(input string name, input logic [7:0] exp);
        if (rd_idx < popped.size()) begin
            check(name, popped[rd_idx], exp);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no byte popped, expected 0x%0h", name, exp);
        end
        rd_idx++;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        for (int i = 0; i < 300 && !bus.rx_valid; i++) step(1);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        check_next(name, exp);
    endtask

    task automatic drain();
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 100 && bus.rx_valid; i++) step(1);
        bus.rx_ready = 1'b0;
        check("drain_done", bus.rx_valid, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [4:0]  exp_count;
        int unsigned exp_ferr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        int unsigned o0;
        int unsigned k17;

        vecs[0] = '{8'h55, 1'b1, 5'd1, 0};
        vecs[1] = '{8'hA5, 1'b0, 5'd0, 1};
        vecs[2] = '{8'h3C, 1'b1, 5'd1, 0};
        vecs[3] = '{8'h00, 1'b1, 5'd1, 0};
        vecs[4] = '{8'hFF, 1'b1, 5'd1, 0};
        vecs[5] = '{8'h80, 1'b1, 5'd1, 0};
        vecs[6] = '{8'h01, 1'b1, 5'd1, 0};

        bus.rx_ready = 1'b0;
        step(3);
        check("rst_valid", bus.rx_valid, 1'b0);
        check("rst_data", bus.rx_data, 8'h00);
        check("rst_count", bus.fifo_count, 5'd0);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        sys_rstn = 1'b1;
        step(5);

        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            step(24);
            check($sformatf("vec%0d_count", i), bus.fifo_count, vecs[i].exp_count);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_count != 0) pop_expect($sformatf("vec%0d_data", i), vecs[i].data);
        end

        // rx_valid must rise one cycle after the stop-bit count-9 sample.
        send_frame(8'h55, 1'b1);
        check("t1_latency", rise_cyc, frame_k + 157);
        check("t1_count", bus.fifo_count, 5'd1);
        check("t1_data", bus.rx_data, 8'h55);
        pop_expect("t1_pop", 8'h55);
        check("t1_valid_after", bus.rx_valid, 1'b0);
        check("t1_count_after", bus.fifo_count, 5'd0);

        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        step(40);
        check("t2_ferr_once", ferr_cnt - f0, 1);
        check("t2_no_push", bus.fifo_count, 5'd0);
        rx = 1'b1;
        step(10);
        send_frame(8'h3C, 1'b1);
        step(4);
        check("t2_count", bus.fifo_count, 5'd1);
        pop_expect("t2_data", 8'h3C);
        check("t2_ferr_total", ferr_cnt - f0, 1);

        f0 = ferr_cnt;
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(40);
        check("t3_no_push", bus.fifo_count, 5'd0);
        check("t3_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h96, 1'b1);
        step(4);
        pop_expect("t3_after", 8'h96);

        o0 = ovr_cnt;
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
        k17 = frame_k;
        step(4);
        check("t4_count", bus.fifo_count, 5'd16);
        check("t4_ovr_once", ovr_cnt - o0, 1);
        check("t4_ovr_cycle", ovr_cyc, k17 + 156);
        drain();
        for (int b = 0; b < 16; b++) check_next($sformatf("t4_drain%0d", b), 8'(b));
        check("t4_empty", bus.fifo_count, 5'd0);

        o0 = ovr_cnt;
        for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1);
        check("t5_full", bus.fifo_count, 5'd16);
        fork
            send_frame(8'h10, 1'b1);
            begin
                step(156);
                bus.rx_ready = 1'b1;
                step(1);
                check("t5_count_kept", bus.fifo_count, 5'd16);
            end
        join
        drain();
        check("t5_no_ovr", ovr_cnt - o0, 0);
        for (int b = 0; b < 17; b++) check_next($sformatf("t5_drain%0d", b), 8'(b));

        send_frame(8'h77, 1'b1);
        step(4);
        check("t6_pre_count", bus.fifo_count, 5'd1);
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 1);
            step(16);
        end
        rx = 1'b0;
        step(8);
        sys_rstn = 1'b0;
        #1;
        check("t6_rst_valid", bus.rx_valid, 1'b0);
        check("t6_rst_count", bus.fifo_count, 5'd0);
        check("t6_rst_data", bus.rx_data, 8'h00);
        check("t6_rst_ferr", bus.frame_err, 1'b0);
        check("t6_rst_ovr", bus.overrun, 1'b0);
        rx = 1'b1;
        step(4);
        sys_rstn = 1'b1;
        step(20);
        check("t6_post_count", bus.fifo_count, 5'd0);
        send_frame(8'hC3, 1'b1);
        step(30);
        check("t6_count", bus.fifo_count, 5'd1);
        pop_expect("t6_data", 8'hC3);
        step(200);
        check("t6_once", bus.rx_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
